// File: rtl/keypad_entry_controller.sv
// Keypad entry sequencer: collects BCD digits with backspace/clear/enter editing,
// an inactivity auto-clear, and a valid/ready hand-off of the finished command.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_EMPTY   | no digits buffered
// S_ENTRY   | 1..MAX_DIGITS digits buffered, editing and timeout active
// S_PENDING | command presented on cmd_* and held until cmd_ready_i
module keypad_entry_controller #(
  parameter int MAX_DIGITS     = 4,
  parameter int LEN_DW         = 3,
  parameter int TO_DW          = 28,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic                    clk_50MHz_i,
  input  logic                    rst_sync_ha_i,
  input  logic [3:0]              key_i,
  input  logic                    key_valid_i,
  input  logic                    cmd_ready_i,
  output logic                    cmd_valid_o,
  output logic [4*MAX_DIGITS-1:0] cmd_data_o,
  output logic [LEN_DW-1:0]       cmd_len_o,
  output logic                    err_o,
  output logic                    timeout_o,
  output logic                    entry_active_o
);

  localparam int DW = 4 * MAX_DIGITS;
  localparam logic [LEN_DW-1:0] LEN_MAX = LEN_DW'(MAX_DIGITS);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_DW-1:0] TO_LAST = TO_EN ? TO_DW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_ENTRY   = 2'd1,
    S_PENDING = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [DW-1:0]     data_q, data_n;
  logic [LEN_DW-1:0] len_q, len_n;
  logic [TO_DW-1:0]  cnt_q, cnt_n;
  logic              err_q, err_n;
  logic              to_q, to_n;

  always_ff @(posedge clk_50MHz_i) begin
    if (rst_sync_ha_i) begin
      state  <= S_EMPTY;
      data_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      state  <= state_n;
      data_q <= data_n;
      len_q  <= len_n;
      cnt_q  <= cnt_n;
      err_q  <= err_n;
      to_q   <= to_n;
    end
  end

  // The idle counter defaults to zero, so any strobe or any non-ENTRY state clears it.
  always_comb begin
    state_n = state;
    data_n  = data_q;
    len_n   = len_q;
    cnt_n   = '0;
    err_n   = 1'b0;
    to_n    = 1'b0;
    if (state == S_PENDING) begin
      if (key_valid_i) err_n = 1'b1;
      if (cmd_ready_i) begin
        state_n = S_EMPTY;
        data_n  = '0;
        len_n   = '0;
      end
    end else if (key_valid_i) begin
      case (key_i)
        4'hA: begin
          if (len_q != '0) begin
            data_n = data_q >> 4;
            len_n  = len_q - 1'b1;
            if (len_q == LEN_DW'(1)) state_n = S_EMPTY;
          end else begin
            err_n = 1'b1;
          end
        end
        4'hB: begin
          state_n = S_EMPTY;
          data_n  = '0;
          len_n   = '0;
        end
        4'hF: begin
          if (len_q != '0) state_n = S_PENDING;
          else             err_n   = 1'b1;
        end
        4'hC, 4'hD, 4'hE: err_n = 1'b1;
        default: begin
          if (len_q < LEN_MAX) begin
            data_n  = (data_q << 4) | DW'(key_i);
            len_n   = len_q + 1'b1;
            state_n = S_ENTRY;
          end else begin
            err_n = 1'b1;
          end
        end
      endcase
    end else if (state == S_ENTRY && TO_EN) begin
      if (cnt_q == TO_LAST) begin
        state_n = S_EMPTY;
        data_n  = '0;
        len_n   = '0;
        to_n    = 1'b1;
      end else begin
        cnt_n = cnt_q + 1'b1;
      end
    end
  end

  assign cmd_valid_o    = (state == S_PENDING);
  assign entry_active_o = (state == S_ENTRY);
  assign cmd_data_o     = data_q;
  assign cmd_len_o      = len_q;
  assign err_o          = err_q;
  assign timeout_o      = to_q;

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Bench for keypad_entry_controller: directed vector table, hand sequences for
// hold/timeout corners, and random traffic against a queue-based reference model.
module tb_keypad_entry_controller;

  localparam int MAXD = 4;
  localparam int TOC  = 100;

  logic        clk = 1'b0;
  logic        rst, kv, rdy;
  logic [3:0]  key;
  logic        cmd_valid, err, tmo, entry;
  logic [15:0] cmd_data;
  logic [2:0]  cmd_len;

  keypad_entry_controller #(
    .MAX_DIGITS(MAXD), .LEN_DW(3), .TO_DW(28), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk_50MHz_i(clk), .rst_sync_ha_i(rst), .key_i(key), .key_valid_i(kv),
    .cmd_ready_i(rdy), .cmd_valid_o(cmd_valid), .cmd_data_o(cmd_data),
    .cmd_len_o(cmd_len), .err_o(err), .timeout_o(tmo), .entry_active_o(entry)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: digits kept oldest-first in a queue, idle cycles counted directly.
  int mq[$];
  bit m_pend, m_err, m_to;
  int m_idle;

  function automatic logic [15:0] m_data();
    logic [15:0] d = '0;
    foreach (mq[i]) d = (d << 4) | 16'(mq[i]);
    return d;
  endfunction

  function automatic void model_step(input bit r, input bit v, input int k, input bit rd);
    m_err = 0;
    m_to  = 0;
    if (r) begin
      mq.delete(); m_pend = 0; m_idle = 0;
    end else if (m_pend) begin
      if (v) m_err = 1;
      if (rd) begin m_pend = 0; mq.delete(); end
      m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      if (k <= 9) begin
        if (mq.size() < MAXD) mq.push_back(k); else m_err = 1;
      end else if (k == 10) begin
        if (mq.size() > 0) void'(mq.pop_back()); else m_err = 1;
      end else if (k == 11) begin
        mq.delete();
      end else if (k == 15) begin
        if (mq.size() > 0) m_pend = 1; else m_err = 1;
      end else begin
        m_err = 1;
      end
    end else if (mq.size() > 0) begin
      m_idle++;
      if (m_idle == TOC) begin mq.delete(); m_to = 1; m_idle = 0; end
    end
  endfunction

  task automatic apply(input bit r, input bit v, input int k, input bit rd);
    @(negedge clk);
    rst = r; kv = v; key = 4'(k); rdy = rd;
    @(posedge clk);
    #1;
    model_step(r, v, k, rd);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(cmd_valid), 32'(m_pend));
    chk({tag, ".data"},  32'(cmd_data),  32'(m_data()));
    chk({tag, ".len"},   32'(cmd_len),   32'(mq.size()));
    chk({tag, ".err"},   32'(err),       32'(m_err));
    chk({tag, ".tmo"},   32'(tmo),       32'(m_to));
    chk({tag, ".entry"}, 32'(entry),     32'(!m_pend && mq.size() > 0));
  endtask

  typedef struct {
    bit r; bit v; int k; bit rd;
    bit ev; logic [15:0] ed; int el; bit ee; bit et; bit ea;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit r, input bit v, input int k, input bit rd,
                     input bit ev, input logic [15:0] ed, input int el,
                     input bit ee, input bit ea);
    vec_t x;
    x.r = r; x.v = v; x.k = k; x.rd = rd;
    x.ev = ev; x.ed = ed; x.el = el; x.ee = ee; x.et = 1'b0; x.ea = ea;
    vecs.push_back(x);
  endtask

  initial begin
    int fired_at;
    rst = 1'b1; kv = 1'b0; key = 4'h0; rdy = 1'b0;

    //   r v  k  rd   valid data     len err entry
    add(1,0, 0, 0,   0, 16'h0000, 0, 0, 0);
    add(0,1, 1, 0,   0, 16'h0001, 1, 0, 1);
    add(0,1, 2, 0,   0, 16'h0012, 2, 0, 1);
    add(0,1, 3, 0,   0, 16'h0123, 3, 0, 1);
    add(0,1,15, 0,   1, 16'h0123, 3, 0, 0);
    add(0,0, 0, 1,   0, 16'h0000, 0, 0, 0);
    add(0,1,15, 0,   0, 16'h0000, 0, 1, 0);
    add(0,0, 0, 0,   0, 16'h0000, 0, 0, 0);
    add(0,1,12, 0,   0, 16'h0000, 0, 1, 0);
    add(0,1,11, 0,   0, 16'h0000, 0, 0, 0);
    add(0,1, 9, 0,   0, 16'h0009, 1, 0, 1);
    add(0,1, 8, 0,   0, 16'h0098, 2, 0, 1);
    add(0,1, 7, 0,   0, 16'h0987, 3, 0, 1);
    add(0,1, 6, 0,   0, 16'h9876, 4, 0, 1);
    add(0,1, 5, 0,   0, 16'h9876, 4, 1, 1);
    add(0,1,10, 0,   0, 16'h0987, 3, 0, 1);
    add(0,1,15, 0,   1, 16'h0987, 3, 0, 0);
    add(0,1, 7, 1,   0, 16'h0000, 0, 1, 0);
    add(0,1, 4, 0,   0, 16'h0004, 1, 0, 1);
    add(0,1, 2, 0,   0, 16'h0042, 2, 0, 1);
    add(0,1,15, 0,   1, 16'h0042, 2, 0, 0);
    add(0,1, 7, 0,   1, 16'h0042, 2, 1, 0);
    add(0,1, 7, 1,   0, 16'h0000, 0, 1, 0);
    add(0,1, 1, 0,   0, 16'h0001, 1, 0, 1);
    add(0,1, 2, 0,   0, 16'h0012, 2, 0, 1);
    add(1,1, 3, 0,   0, 16'h0000, 0, 0, 0);
    add(0,1, 3, 0,   0, 16'h0003, 1, 0, 1);
    add(0,1,15, 0,   1, 16'h0003, 1, 0, 0);
    add(0,0, 0, 1,   0, 16'h0000, 0, 0, 0);
    add(0,1, 5, 0,   0, 16'h0005, 1, 0, 1);
    add(0,1,10, 0,   0, 16'h0000, 0, 0, 0);
    add(0,1,10, 0,   0, 16'h0000, 0, 1, 0);
    add(0,0, 0, 1,   0, 16'h0000, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].v, vecs[i].k, vecs[i].rd);
      chk($sformatf("vec%0d.valid", i), 32'(cmd_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d.data", i),  32'(cmd_data),  32'(vecs[i].ed));
      chk($sformatf("vec%0d.len", i),   32'(cmd_len),   32'(vecs[i].el));
      chk($sformatf("vec%0d.err", i),   32'(err),       32'(vecs[i].ee));
      chk($sformatf("vec%0d.tmo", i),   32'(tmo),       32'(vecs[i].et));
      chk($sformatf("vec%0d.entry", i), 32'(entry),     32'(vecs[i].ea));
    end

    // Command held stable while downstream stalls.
    apply(0, 1, 1, 0); apply(0, 1, 2, 0); apply(0, 1, 3, 0); apply(0, 1, 15, 0);
    check_model("hold.enter");
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, 0, 0);
      check_model("hold");
      chk("hold.data_const", 32'(cmd_data), 32'h0123);
    end
    apply(0, 0, 0, 1);
    check_model("hold.accept");

    // Timeout fires on the 100th idle cycle after the strobe.
    apply(0, 1, 4, 0);
    check_model("to.key");
    fired_at = -1;
    for (int i = 1; i <= TOC + 5; i++) begin
      apply(0, 0, 0, 0);
      check_model("to.idle");
      if (tmo === 1'b1 && fired_at < 0) fired_at = i;
    end
    chk("to.latency", 32'(fired_at), 32'(TOC));

    // Strobe coinciding with terminal count wins over the timeout.
    apply(0, 1, 4, 0);
    for (int i = 1; i < TOC; i++) apply(0, 0, 0, 0);
    check_model("to.pre_tc");
    apply(0, 1, 5, 0);
    check_model("to.tc_key");
    chk("to.tc_data", 32'(cmd_data), 32'h0045);
    chk("to.tc_no_pulse", 32'(tmo), 32'h0);
    apply(0, 1, 11, 0);
    check_model("to.clear");

    // Random traffic: dense keys first, then sparse keys so timeouts occur.
    for (int i = 0; i < 4000; i++) begin
      bit r, v, rd;
      int k, rr;
      r  = ($urandom_range(0, 199) == 0);
      v  = (i < 2000) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 2);
      rr = $urandom_range(0, 19);
      k  = (rr < 12) ? (rr % 10) : $urandom_range(10, 15);
      rd = ($urandom_range(0, 3) == 0);
      apply(r, v, k, rd);
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
